stopwatch_bcd: RTL
==================

Name: stopwatch_bcd

Overview:
- Consumes the 100 Hz square wave produced by the clock divider stage.
- Counts elapsed time as MM:SS.hh in six BCD digits, under start/stop/clear control.
- Drives the seven-segment decode stage directly downstream.
- Runs entirely in the 50 MHz domain. The divided clock is used only as a data input and is edge-detected; it is never used as a clock.

Parameters:
- MAX_MIN, default 59, highest minute value before wrap (legal 1..99).
- STARTUP_RUN, default 0, when 1 the FSM leaves reset in RUN instead of IDLE.

Ports:
- clk  input  1  50 MHz system clock.
- reset_n  input  1  synchronous, active-low reset.
- tick_in  input  1  100 Hz square wave from the divider, registered in the clk domain.
- start_stop  input  1  debounced button level, active-high. A rising edge toggles run/pause.
- clear  input  1  debounced button level, active-high. A level-high value clears the count.
- lap  input  1  debounced button level, active-high. Used only with LAP_HOLD_EN.
- cs_ones, cs_tens  output  4 each  hundredths digits (BCD).
- sec_ones, sec_tens  output  4 each  seconds digits (BCD).
- min_ones, min_tens  output  4 each  minutes digits (BCD).
- running  output  1  high while the FSM is in RUN.
- wrap_pulse  output  1  one-cycle pulse when the count wraps MAX_MIN:59.99 -> 00:00.00.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (reset_n). All registers update only on posedge clk.
- Reset values:
  - All digits 0.
  - running = STARTUP_RUN.
  - wrap_pulse = 0.
  - State = IDLE, or RUN if STARTUP_RUN = 1.
  - Edge-detect registers: tick_d = 1, ss_d = 1, lap_d = 1. This prevents a false edge on reset release.
- Edge detection:
  - tick_pulse = tick_in & ~tick_d.
  - ss_pulse = start_stop & ~ss_d.
  - Each is one clk cycle wide.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: ss_pulse -> RUN. Ticks are ignored.
  - RUN: ss_pulse -> PAUSE. Each tick_pulse advances the count.
  - PAUSE: ss_pulse -> RUN. Ticks are ignored and digits hold.
  - Any state with clear = 1 -> IDLE, all digits 0. Clear is level-sensitive and has priority over ss_pulse and tick_pulse in the same cycle.
- Count latency: a tick_pulse in RUN at cycle N shows the new digits on outputs at cycle N+1.
- Digit carry chain (all in the same cycle):
  - cs_ones 9 -> 0, carry into cs_tens.
  - cs_tens 9 -> 0, carry into sec_ones.
  - sec_ones 9 -> 0, carry into sec_tens.
  - sec_tens 5 -> 0, carry into minutes.
  - Minutes count as a two-digit BCD pair up to MAX_MIN.
- Wrap:
  - At MAX_MIN:59.99 plus a tick, all digits become 0 and wrap_pulse = 1 for exactly one cycle.
  - The FSM stays in RUN.
- Digits never hold non-BCD values. No digit exceeds 9, and sec_tens never exceeds 5.
- running is registered and equals (state == RUN).
- Simultaneous ss_pulse and tick_pulse in RUN: the tick is counted, then the FSM enters PAUSE.
- Simultaneous ss_pulse and tick_pulse in PAUSE: the tick is not counted, then the FSM enters RUN.
- reset_n low mid-count: the next posedge restores all reset values, regardless of state.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - A rising edge of lap in RUN latches the live digits into a display register and sets hold = 1. Digit outputs then show the latched value while internal counting continues.
  - A second lap rising edge, or clear, or entering PAUSE, sets hold = 0 and returns outputs to the live digits.
  - The latch takes effect the cycle after the edge.
- Undefined: lap is ignored, no display register exists, and outputs always show the live digits.

Decomposition:
- Shared package/include holds:
  - State encodings: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2.
  - BCD limit constants: DIG_MAX = 4'd9, SEC_TENS_MAX = 4'd5.
- One sub-module, bcd_digit: a single BCD digit counter.
  - Ports: clk, reset_n, clr, inc, limit, out q, out carry.
  - Instanced six times in the carry chain.
  - The minutes pair compares against MAX_MIN split into tens and ones.
- Edge detectors stay inline.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with tick_in = 1 -> all digits 0, running = 0; no count on release.
- Start and count: ss_pulse, then 150 tick_in rising edges -> digits read 00:01.50, running = 1.
- Pause: ss_pulse at 00:00.37, then 20 ticks -> digits stay 00:00.37. A further ss_pulse plus 3 ticks -> 00:00.40.
- Clear priority: clear = 1 in the same cycle as ss_pulse and tick_pulse in RUN at 00:12.34 -> next cycle digits 0, state IDLE, running = 0.
- Wrap with MAX_MIN = 1: preload by ticking to 01:59.99, then 1 tick -> 00:00.00. wrap_pulse is high for exactly 1 cycle and running stays 1.
- Lap (STOPWATCH_LAP_HOLD_EN): lap edge at 00:05.00, then 100 ticks -> outputs show 00:05.00. A second lap edge -> outputs show 00:06.00 next cycle.

Source files
------------

// File: rtl/stopwatch_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_bcd_pkg
// Brief   : Shared FSM state encodings and BCD digit limits for the
//           stopwatch_bcd block.
// Revision: 1.0 - initial release
// ============================================================================
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIG_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/stopwatch_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit
// Brief   : Single BCD digit counter with programmable rollover limit.
//           carry is combinational so a whole chain advances in one cycle.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic [3:0] q,
  output logic       carry
);

  // Rollover happens on the same increment that carries into the next digit
  assign carry = inc && (q == limit);

  // Digit register: clear has priority over increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == limit) ? 4'd0 : q + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_bcd
// Brief   : MM:SS.hh BCD stopwatch with start/stop/clear control, driven by
//           an edge-detected 100 Hz tick sampled in the system clock domain.
//           Optional lap-hold display enabled by STOPWATCH_LAP_HOLD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter bit STARTUP_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap_pulse
);

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);
  localparam state_t     RESET_STATE  = STARTUP_RUN ? ST_RUN : ST_IDLE;

  logic   tick_d, ss_d;
  logic   tick_pulse, ss_pulse, count_en;
  state_t state, next_state;

  logic [3:0] q_cs_o, q_cs_t, q_s_o, q_s_t, q_m_o, q_m_t;
  logic       c_cs_o, c_cs_t, c_s_o, c_s_t, c_m_o, c_m_t;
  logic [3:0] min_ones_limit;
  logic [23:0] live_bus, shown;

  // Edge-detect history registers; reset high so release never fakes an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_d <= 1'b1;
      ss_d   <= 1'b1;
    end else begin
      tick_d <= tick_in;
      ss_d   <= start_stop;
    end
  end

  assign tick_pulse = tick_in & ~tick_d;
  assign ss_pulse   = start_stop & ~ss_d;

  // State register and registered running flag tracking the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      running <= STARTUP_RUN;
    end else begin
      state   <= next_state;
      running <= (next_state == ST_RUN);
    end
  end

  // Next-state logic: clear dominates, otherwise start_stop edge toggles
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else if (ss_pulse) begin
      case (state)
        ST_IDLE:  next_state = ST_RUN;
        ST_RUN:   next_state = ST_PAUSE;
        ST_PAUSE: next_state = ST_RUN;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Ticks count only while running; a pause request in the same cycle still
  // lets this tick through because the decision uses the current state
  assign count_en = (state == ST_RUN) && tick_pulse;

  // Minute ones roll over early when the tens digit is at its top value
  assign min_ones_limit = (q_m_t == MAX_MIN_TENS) ? MAX_MIN_ONES : DIG_MAX;

  bcd_digit u_cs_ones (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(count_en),
                       .limit(DIG_MAX), .q(q_cs_o), .carry(c_cs_o));
  bcd_digit u_cs_tens (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(c_cs_o),
                       .limit(DIG_MAX), .q(q_cs_t), .carry(c_cs_t));
  bcd_digit u_sec_ones (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(c_cs_t),
                        .limit(DIG_MAX), .q(q_s_o), .carry(c_s_o));
  bcd_digit u_sec_tens (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(c_s_o),
                        .limit(SEC_TENS_MAX), .q(q_s_t), .carry(c_s_t));
  bcd_digit u_min_ones (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(c_s_t),
                        .limit(min_ones_limit), .q(q_m_o), .carry(c_m_o));
  bcd_digit u_min_tens (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(c_m_o),
                        .limit(MAX_MIN_TENS), .q(q_m_t), .carry(c_m_t));

  // Carry out of the top digit marks the full-scale wrap to zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= c_m_t & ~clear;
    end
  end

  assign live_bus = {q_m_t, q_m_o, q_s_t, q_s_o, q_cs_t, q_cs_o};

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        lap_d, lap_pulse, hold;
  logic [23:0] disp;

  assign lap_pulse = lap & ~lap_d;

  // Lap hold: freeze a snapshot on the display while counting continues
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lap_d <= 1'b1;
      hold  <= 1'b0;
      disp  <= 24'd0;
    end else begin
      lap_d <= lap;
      if (clear || ((state == ST_RUN) && ss_pulse)) begin
        hold <= 1'b0;
      end else if ((state == ST_RUN) && lap_pulse) begin
        hold <= ~hold;
        if (!hold) begin
          disp <= live_bus;
        end
      end
    end
  end

  assign shown = hold ? disp : live_bus;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign shown      = live_bus;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = shown;

endmodule
`default_nettype wire
